// File: rtl/frog_referee_pkg.sv
// rtl/frog_referee_pkg.sv - shared game constants: state encoding, coordinate width, display limits
package frog_referee_pkg;

  localparam int COORD_W  = 12;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FREEZE = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

endpackage

// File: rtl/frog_referee_box_overlap.sv
// rtl/frog_referee_box_overlap.sv - strict (edge-exclusive) overlap test of two axis-aligned boxes
module box_overlap
  import frog_referee_pkg::*;
(
  input  logic [COORD_W-1:0] a_x1,
  input  logic [COORD_W-1:0] a_x2,
  input  logic [COORD_W-1:0] a_y1,
  input  logic [COORD_W-1:0] a_y2,
  input  logic [COORD_W-1:0] b_x1,
  input  logic [COORD_W-1:0] b_x2,
  input  logic [COORD_W-1:0] b_y1,
  input  logic [COORD_W-1:0] b_y2,
  output logic               overlap
);

  // Touching edges are not a collision, so every side uses a strict compare.
  assign overlap = (a_x1 < b_x2) && (a_x2 > b_x1) && (a_y1 < b_y2) && (a_y2 > b_y1);

endmodule

// File: rtl/frog_referee.sv
// rtl/frog_referee.sv - frog game rules: collision/goal evaluation, lives, score and game state machine
module frog_referee
  import frog_referee_pkg::*;
#(
  parameter int N_OBS      = 4,
  parameter int LIVES      = 3,
  parameter int GOAL_Y     = 40,
  parameter int HIT_FRAMES = 60,
  parameter int SCORE_W    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ani_stb,
  input  logic                     i_start,
  input  logic [COORD_W-1:0]       i_frog_x1,
  input  logic [COORD_W-1:0]       i_frog_x2,
  input  logic [COORD_W-1:0]       i_frog_y1,
  input  logic [COORD_W-1:0]       i_frog_y2,
  input  logic [COORD_W*N_OBS-1:0] i_obs_x1,
  input  logic [COORD_W*N_OBS-1:0] i_obs_x2,
  input  logic [COORD_W*N_OBS-1:0] i_obs_y1,
  input  logic [COORD_W*N_OBS-1:0] i_obs_y2,
  output logic                     o_frog_rst,
  output logic                     o_animate,
  output logic                     o_hit,
  output logic                     o_goal,
  output logic [3:0]               o_lives,
  output logic [SCORE_W-1:0]       o_score,
  output logic [1:0]               o_state
);

  localparam int CNT_W = $clog2(HIT_FRAMES + 1);
  localparam logic [COORD_W-1:0] GOAL_Y_C     = COORD_W'(GOAL_Y);
  localparam logic [3:0]         LIVES_C      = 4'(LIVES);
  localparam logic [CNT_W-1:0]   HIT_FRAMES_C = CNT_W'(HIT_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  state_t               state_q, state_d;
  logic [3:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 goal_q, goal_d;
  logic [N_OBS-1:0]     obs_hit;
  logic                 any_hit;
  logic                 at_goal;

  for (genvar k = 0; k < N_OBS; k++) begin : g_obs
    box_overlap u_overlap (
      .a_x1    (i_frog_x1),
      .a_x2    (i_frog_x2),
      .a_y1    (i_frog_y1),
      .a_y2    (i_frog_y2),
      .b_x1    (i_obs_x1[COORD_W*k +: COORD_W]),
      .b_x2    (i_obs_x2[COORD_W*k +: COORD_W]),
      .b_y1    (i_obs_y1[COORD_W*k +: COORD_W]),
      .b_y2    (i_obs_y2[COORD_W*k +: COORD_W]),
      .overlap (obs_hit[k])
    );
  end

  assign any_hit = |obs_hit;
  assign at_goal = (i_frog_y1 <= GOAL_Y_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      lives_q <= '0;
      score_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      goal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      goal_q  <= goal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    goal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_C;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        if (i_ani_stb) begin
          // Hit wins over goal when both land in the same frame.
          if (any_hit) begin
            hit_d = 1'b1;
            if (lives_q <= 4'd1) begin
              lives_d = '0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_q - 4'd1;
              cnt_d   = HIT_FRAMES_C;
              state_d = ST_FREEZE;
            end
          end else if (at_goal) begin
            goal_d  = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            cnt_d   = CNT_ONE;
            state_d = ST_FREEZE;
          end
        end
      end
      ST_FREEZE: begin
        if (i_ani_stb) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_OVER: begin
        if (i_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_frog_rst = (state_q != ST_PLAY);
  assign o_animate  = (state_q == ST_PLAY) || (state_q == ST_FREEZE);
  assign o_hit      = hit_q;
  assign o_goal     = goal_q;
  assign o_lives    = lives_q;
  assign o_score    = score_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_frog_referee.sv
// tb/tb_frog_referee.sv - self-checking bench for frog_referee: directed game scenarios plus randomized play
module tb_frog_referee;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, stb, start;
  logic [11:0]   fx1, fx2, fy1, fy2;
  logic [12*N-1:0] ox1, ox2, oy1, oy2;
  logic          frog_rst, animate, hit, goal;
  logic [3:0]    lives;
  logic [7:0]    score;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  // reference model state
  int m_state, m_lives, m_score, m_cnt, m_hit, m_goal;

  always #5 clk = ~clk;

  frog_referee dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_start(start),
    .i_frog_x1(fx1), .i_frog_x2(fx2), .i_frog_y1(fy1), .i_frog_y2(fy2),
    .i_obs_x1(ox1), .i_obs_x2(ox2), .i_obs_y1(oy1), .i_obs_y2(oy2),
    .o_frog_rst(frog_rst), .o_animate(animate), .o_hit(hit), .o_goal(goal),
    .o_lives(lives), .o_score(score), .o_state(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_any_hit();
    for (int k = 0; k < N; k++) begin
      int ax1 = fx1, ax2 = fx2, ay1 = fy1, ay2 = fy2;
      int bx1 = ox1[12*k +: 12], bx2 = ox2[12*k +: 12];
      int by1 = oy1[12*k +: 12], by2 = oy2[12*k +: 12];
      if (ax1 < bx2 && ax2 > bx1 && ay1 < by2 && ay2 > by1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Game-rule model: 0 idle, 1 play, 2 freeze, 3 over.
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_lives = 0; m_score = 0; m_cnt = 0; m_hit = 0; m_goal = 0;
    end else begin
      m_hit = 0; m_goal = 0;
      if (m_state == 0) begin
        if (start) begin m_state = 1; m_lives = 3; m_score = 0; end
      end else if (m_state == 1) begin
        if (stb && model_any_hit()) begin
          m_hit = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_cnt = 60; end
        end else if (stb && int'(fy1) <= 40) begin
          m_goal = 1;
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_state = 2; m_cnt = 1;
        end
      end else if (m_state == 2) begin
        if (stb) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_state = 1;
        end
      end else begin
        if (start) m_state = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("m_state", state, m_state);
      chk("m_lives", lives, m_lives);
      chk("m_score", score, m_score);
      chk("m_hit", hit, m_hit);
      chk("m_goal", goal, m_goal);
      chk("m_frog_rst", frog_rst, (m_state != 1) ? 1 : 0);
      chk("m_animate", animate, (m_state == 1 || m_state == 2) ? 1 : 0);
      chk("hit_goal_excl", hit & goal, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe();
    stb = 1'b1; step(); stb = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic obs_far();
    for (int k = 0; k < N; k++) begin
      ox1[12*k +: 12] = 12'd2000; ox2[12*k +: 12] = 12'd2010;
      oy1[12*k +: 12] = 12'd2000; oy2[12*k +: 12] = 12'd2010;
    end
  endtask

  task automatic set_frog(input int x1, input int x2, input int y1, input int y2);
    fx1 = 12'(x1); fx2 = 12'(x2); fy1 = 12'(y1); fy2 = 12'(y2);
  endtask

  task automatic set_obs0(input int x1, input int x2, input int y1, input int y2);
    ox1[11:0] = 12'(x1); ox2[11:0] = 12'(x2); oy1[11:0] = 12'(y1); oy2[11:0] = 12'(y2);
  endtask

  task automatic run_freeze(input int n);
    for (int i = 0; i < n; i++) begin strobe(); step(); end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; start = 1'b0;
    set_frog(309, 331, 449, 471);
    obs_far();
    step();
    checking = 1;
    step();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 0);
    chk("rst_frog_rst", frog_rst, 1);
    chk("rst_animate", animate, 0);
    rst = 1'b0;
    step();

    pulse_start();
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_animate", animate, 1);
    chk("start_frog_rst", frog_rst, 0);

    // collision
    set_obs0(320, 360, 440, 480);
    strobe();
    chk("hit_pulse", hit, 1);
    chk("hit_lives", lives, 2);
    chk("hit_state", state, 2);
    chk("hit_frog_rst", frog_rst, 1);
    obs_far();
    step();
    chk("hit_one_cycle", hit, 0);
    run_freeze(59);
    chk("freeze_59", state, 2);
    run_freeze(1);
    chk("freeze_done_state", state, 1);
    chk("freeze_done_frog_rst", frog_rst, 0);

    // edge touch
    set_obs0(331, 360, 440, 480);
    strobe();
    chk("touch_hit", hit, 0);
    chk("touch_state", state, 1);
    obs_far();

    // goal
    set_frog(309, 331, 40, 62);
    strobe();
    chk("goal_pulse", goal, 1);
    chk("goal_score", score, 1);
    chk("goal_state", state, 2);
    step();
    chk("goal_hold", state, 2);
    strobe();
    chk("goal_back", state, 1);
    set_frog(309, 331, 41, 63);
    strobe();
    chk("nogoal_41", goal, 0);
    chk("nogoal_state", state, 1);

    // hit and goal in the same frame
    set_frog(100, 120, 30, 50);
    set_obs0(110, 130, 20, 60);
    strobe();
    chk("prio_hit", hit, 1);
    chk("prio_goal", goal, 0);
    chk("prio_score", score, 1);
    chk("prio_lives", lives, 1);
    obs_far();
    run_freeze(60);

    // last life
    set_frog(309, 331, 449, 471);
    set_obs0(320, 360, 440, 480);
    strobe();
    chk("over_lives", lives, 0);
    chk("over_state", state, 3);
    chk("over_animate", animate, 0);
    chk("over_score", score, 1);
    obs_far();
    step();
    pulse_start();
    chk("over_to_idle", state, 0);
    step();
    pulse_start();
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);

    // reset mid-freeze
    set_obs0(320, 360, 440, 480);
    strobe();
    obs_far();
    run_freeze(30);
    chk("mid_freeze", state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_state", state, 0);
    chk("mrst_frog_rst", frog_rst, 1);
    step();
    pulse_start();
    chk("mrst_restart", state, 1);

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      int a, b;
      stb   = ($urandom_range(0, 1) == 1);
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 255) == 0);
      a = $urandom_range(0, 150);
      b = ($urandom_range(0, 9) == 0) ? 4090 : $urandom_range(0, 120);
      set_frog(a, a + $urandom_range(1, 30), b, b + $urandom_range(1, 30));
      for (int k = 0; k < N; k++) begin
        a = $urandom_range(0, 170);
        b = $urandom_range(0, 140);
        ox1[12*k +: 12] = 12'(a); ox2[12*k +: 12] = 12'(a + $urandom_range(0, 25));
        oy1[12*k +: 12] = 12'(b); oy2[12*k +: 12] = 12'(b + $urandom_range(0, 25));
      end
      step();
    end
    stb = 1'b0; start = 1'b0; rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
